// File: rtl/mcpu_program_loader.sv
// rtl/mcpu_program_loader.sv - zero-fills MCPU instruction RAM, then loads a streamed image into it
// Optional trailer checksum word after the s_last word: define MCPU_LOADER_CHECKSUM_EN.
module mcpu_program_loader #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_SIZE-1:0]  s_data,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LP_FULL      = (ADDR_WIDTH+1)'(RAM_SIZE);
  localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE   = (ADDR_WIDTH+1)'(1);

  // S_LAST is the cycle in which the final program word's write is on the bus.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_LAST, S_CHECK, S_RUN, S_ERR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s_ready, w_s_ready_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WORD_SIZE-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_cpu_reset, w_cpu_reset_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;
  logic [ADDR_WIDTH:0]   r_word_count, w_word_count_nxt;
  logic                  w_xfer;
`ifdef MCPU_LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0]  r_sum, w_sum_nxt;
`endif

  assign w_xfer = s_valid && r_s_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_s_ready_nxt    = r_s_ready;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_cpu_reset_nxt  = r_cpu_reset;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
    w_word_count_nxt = r_word_count;
`ifdef MCPU_LOADER_CHECKSUM_EN
    w_sum_nxt        = r_sum;
`endif
    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          w_state_nxt      = S_CLEAR;
          w_s_ready_nxt    = 1'b0;
          w_mem_we_nxt     = 1'b1;
          w_mem_addr_nxt   = '0;
          w_mem_wdata_nxt  = '0;
          w_cpu_reset_nxt  = 1'b1;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_error_nxt      = 1'b0;
          w_word_count_nxt = '0;
`ifdef MCPU_LOADER_CHECKSUM_EN
          w_sum_nxt        = '0;
`endif
        end
      end
      S_CLEAR: begin
        w_mem_wdata_nxt = '0;
        if (r_mem_addr == LP_LAST_ADDR) begin
          w_state_nxt      = S_LOAD;
          w_s_ready_nxt    = 1'b1;
          w_word_count_nxt = '0;
        end else begin
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = r_mem_addr + LP_ADDR_ONE;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (r_word_count == LP_FULL) begin
            // A 257th program word: drop it and stop accepting.
            w_state_nxt   = S_ERR;
            w_s_ready_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_error_nxt   = 1'b1;
          end else begin
            w_mem_we_nxt     = 1'b1;
            w_mem_addr_nxt   = r_word_count[ADDR_WIDTH-1:0];
            w_mem_wdata_nxt  = s_data;
            w_word_count_nxt = r_word_count + LP_CNT_ONE;
`ifdef MCPU_LOADER_CHECKSUM_EN
            w_sum_nxt        = r_sum + s_data;
            if (s_last) begin
              w_state_nxt = S_CHECK;
            end
`else
            if (s_last) begin
              w_state_nxt   = S_LAST;
              w_s_ready_nxt = 1'b0;
            end
`endif
          end
        end
      end
      S_LAST: begin
        w_state_nxt     = S_RUN;
        w_cpu_reset_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b1;
      end
`ifdef MCPU_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) begin
          w_s_ready_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          if (s_data == r_sum) begin
            w_state_nxt     = S_RUN;
            w_cpu_reset_nxt = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt = S_ERR;
            w_error_nxt = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_s_ready    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
`ifdef MCPU_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_cpu_reset  <= w_cpu_reset_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_word_count <= w_word_count_nxt;
`ifdef MCPU_LOADER_CHECKSUM_EN
      r_sum        <= w_sum_nxt;
`endif
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_mcpu_program_loader.sv
// tb/tb_mcpu_program_loader.sv - scoreboard bench for mcpu_program_loader
// Expected RAM writes are queued as stimulus is issued; a negedge monitor pops and compares them.
module tb_mcpu_program_loader;
  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_last;
  logic [15:0] s_data;
  logic        s_ready, mem_we, cpu_reset, busy, done, error;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [15:0] exp_ram[256];
  logic [15:0] dut_ram[256];
  logic [15:0] img[300];
  int          exp_cnt = 0;
`ifdef MCPU_LOADER_CHECKSUM_EN
  logic [15:0] tr_delta = 16'h0;
`endif

  always #5 clk = ~clk;

  mcpu_program_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      dut_ram[mem_addr] = mem_wdata;
      if (exp_q.size() == 0)
        chk("unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'hFFFFFFFF);
      else
        chk("ram_write", {8'h0, mem_addr, mem_wdata}, {8'h0, exp_q.pop_front()});
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    for (int a = 0; a < 256; a++) begin
      exp_q.push_back({a[7:0], 16'h0});
      exp_ram[a] = 16'h0;
    end
    exp_cnt = 0;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
  endtask

  task automatic wait_ready(input bit junk);
    int n = 0;
    s_valid = junk; s_last = junk; s_data = 16'hBAD0;
    while (s_ready !== 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("ready_timeout", n < 400, 1);
    chk("clear_q_empty", exp_q.size(), 0);
  endtask

  // mode 0: valid every cycle, 1: valid toggles, 2: random valid
  task automatic send_image(input int n, input bit with_last, input int mode, input int stop_after);
    int i = 0;
    int cyc_n = 0;
    bit v;
`ifdef MCPU_LOADER_CHECKSUM_EN
    logic [15:0] sum;
    bit sent;
`endif
    while (i < n && cyc_n < 2000 && !(stop_after >= 0 && i >= stop_after)) begin
      v = (mode == 0) || (mode == 1 && cyc_n % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
      s_valid = v;
      s_data = img[i];
      s_last = with_last && (i == n - 1);
      if (v && s_ready === 1'b1) begin
        if (exp_cnt < 256) begin
          exp_q.push_back({exp_cnt[7:0], img[i]});
          exp_ram[exp_cnt] = img[i];
        end
        exp_cnt++;
        i++;
      end
      cyc();
      cyc_n++;
    end
`ifdef MCPU_LOADER_CHECKSUM_EN
    if (with_last && stop_after < 0) begin
      sum = 16'h0;
      for (int k = 0; k < n; k++) sum = sum + img[k];
      sent = 1'b0;
      while (!sent && cyc_n < 2000) begin
        s_valid = (mode == 0) || ($urandom_range(0, 1) == 1);
        s_data = sum + tr_delta;
        s_last = 1'b0;
        if (s_valid && s_ready === 1'b1) sent = 1'b1;
        cyc();
        cyc_n++;
      end
    end
`endif
    s_valid = 1'b0; s_last = 1'b0;
    chk("send_timeout", cyc_n < 2000, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk("settle_timeout", n < 50, 1);
  endtask

  task automatic cmp_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++)
      if (dut_ram[a] !== exp_ram[a]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic check_run(input int n);
    chk("run_done", done, 1);
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_busy", busy, 0);
    chk("run_error", error, 0);
    chk("run_ready", s_ready, 0);
    chk("run_word_count", word_count, n);
    chk("run_q_empty", exp_q.size(), 0);
    cmp_ram("run_ram");
  endtask

  task automatic check_err(input int n);
    chk("err_error", error, 1);
    chk("err_cpu_reset", cpu_reset, 1);
    chk("err_busy", busy, 0);
    chk("err_done", done, 0);
    chk("err_ready", s_ready, 0);
    chk("err_word_count", word_count, n);
    chk("err_q_empty", exp_q.size(), 0);
    cmp_ram("err_ram");
  endtask

  initial begin
    int lens[3];
    reset = 1'b0; start = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0;
    for (int a = 0; a < 256; a++) begin
      dut_ram[a] = 16'hDEAD;
      exp_ram[a] = 16'hDEAD;
    end
    cyc(); cyc();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    reset = 1'b1; start = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 0);
    chk("idle_cpu_reset", cpu_reset, 1);

    img[0] = 16'h1030; img[1] = 16'h1123; img[2] = 16'h2064; img[3] = 16'h2165;
    img[4] = 16'h3264; img[5] = 16'h3365; img[6] = 16'h5423; img[7] = 16'h6523;
    do_start(); wait_ready(1'b1); send_image(8, 1'b1, 0, -1); wait_idle(); check_run(8);
    do_start(); wait_ready(1'b0); send_image(8, 1'b1, 1, -1); wait_idle(); check_run(8);

    lens[0] = 256; lens[1] = $urandom_range(2, 255); lens[2] = 1;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 300; k++) img[k] = 16'($urandom);
      do_start(); wait_ready(1'b0); send_image(lens[t], 1'b1, 2, -1); wait_idle(); check_run(lens[t]);
    end

    for (int k = 0; k < 300; k++) img[k] = 16'($urandom);
    do_start(); wait_ready(1'b0); send_image(257, 1'b0, 2, -1); wait_idle(); check_err(256);
    do_start(); wait_ready(1'b0); cmp_ram("reclear_ram");

    send_image(10, 1'b1, 0, 3);
    reset = 1'b0;
    cyc();
    chk("midrst_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_q_empty", exp_q.size(), 0);
    reset = 1'b1;
    cyc();

`ifdef MCPU_LOADER_CHECKSUM_EN
    img[0] = 16'h0001; img[1] = 16'h0002;
    tr_delta = 16'h0;
    do_start(); wait_ready(1'b0); send_image(2, 1'b1, 0, -1); wait_idle(); check_run(2);
    tr_delta = 16'h1;
    do_start(); wait_ready(1'b0); send_image(2, 1'b1, 0, -1); wait_idle(); check_err(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
